// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all subsystem resets, then releases them one at a time in index
// order, each release gated by a minimum gap and the subsystem's ready acknowledge.
// A soft-reset request accepted in RUN re-runs the whole sequence.
// Optional feature macro: RSTSEQ_ACK_TIMEOUT_EN (forces a missing acknowledge after
// ACK_TIMEOUT waiting cycles and raises a sticky ack_timeout_err).
module reset_sequencer #(
  parameter int unsigned NUM_STAGES    = 3,
  parameter int unsigned ASSERT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ACK_TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  sys_ready,
  output logic                  busy,
  output logic                  soft_ack,
  output logic                  ack_timeout_err
);

  localparam int unsigned      IdxW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_STAGES - 1);

  // Elaboration-time parameter range checks
  if (ASSERT_CYCLES < 1 || ASSERT_CYCLES >= 2 ** CNT_W) begin : g_bad_assert_cycles
    $error("ASSERT_CYCLES out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES >= 2 ** CNT_W) begin : g_bad_gap_cycles
    $error("GAP_CYCLES out of range");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT >= 2 ** CNT_W) begin : g_bad_ack_timeout
    $error("ACK_TIMEOUT out of range");
  end

  typedef enum logic [1:0] {StHold, StRelease, StWaitAck, StRun} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic [1:0]              sync_q;
  logic                    rst_sync;
  logic                    ack_seen;
  logic                    gap_ok;
  logic                    tmo_hit;
  logic                    soft_accept;

  // Reset synchroniser: assertion is immediate, release lands on the 2nd edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync    = ~sync_q[1];
  assign ack_seen    = stage_ack[idx_q];
  assign gap_ok      = (cnt_q >= GapLast);
  assign soft_accept = (state_q == StRun) && soft_req;

  // Next-state logic: hold, release one stage, wait gap+ack, run
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    soft_ack    = 1'b0;
    unique case (state_q)
      StHold: begin
        stage_rst_d = '1;
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        stage_rst_d[idx_q] = 1'b0;
        cnt_d              = '0;
        state_d            = StWaitAck;
      end
      StWaitAck: begin
        // Gap counter saturates so a very late ack never sees a wrapped count
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (gap_ok && (ack_seen || tmo_hit)) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRelease;
          end
        end
      end
      StRun: begin
        if (soft_req) begin
          soft_ack    = 1'b1;
          state_d     = StHold;
          cnt_d       = '0;
          idx_d       = '0;
          stage_rst_d = '1;
        end
      end
      default: begin
        state_d     = StHold;
        cnt_d       = '0;
        idx_d       = '0;
        stage_rst_d = '1;
      end
    endcase
  end

  // State registers; held at reset values while the synchronised reset is active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
    end else if (rst_sync) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
    end
  end

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = (state_q == StWaitAck) && (tmo_q >= TmoLast);

  // Timeout counter runs only while waiting; error is sticky until reset or soft reset
  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (state_q == StWaitAck) begin
      tmo_d = (tmo_q == CntMax) ? tmo_q : tmo_q + 1'b1;
    end
    if (tmo_hit && gap_ok && !ack_seen) begin
      err_d = 1'b1;
    end
    if (soft_accept) begin
      err_d = 1'b0;
    end
  end

  // Timeout state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (rst_sync) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ack_timeout_err = err_q;
`else
  assign tmo_hit         = 1'b0;
  assign ack_timeout_err = 1'b0;
`endif

  assign stage_rst = stage_rst_q;
  assign sys_ready = (state_q == StRun);
  assign busy      = (state_q != StRun);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: an event-time model derived from the release
// schedule rules is compared against the DUT every cycle, plus directed literal checks.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int A = 16;
  localparam int G = 4;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       soft_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic       sys_ready;
  logic       busy;
  logic       soft_ack;
  logic       ack_timeout_err;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES   (N),
    .ASSERT_CYCLES(A),
    .GAP_CYCLES   (G),
    .CNT_W        (8),
    .ACK_TIMEOUT  (T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .soft_req       (soft_req),
    .stage_ack      (stage_ack),
    .stage_rst      (stage_rst),
    .sys_ready      (sys_ready),
    .busy           (busy),
    .soft_ack       (soft_ack),
    .ack_timeout_err(ack_timeout_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hi_edges = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Rising edges seen with reset_n high; the sequence is live once two have passed
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) hi_edges <= 0;
    else if (hi_edges < 2) hi_edges <= hi_edges + 1;
  end

  // Model: released-stage count k and scheduled event cycles
  bit armed = 1'b1;
  bit waiting = 1'b0;
  bit run = 1'b0;
  bit exp_err = 1'b0;
  int k = 0;
  int clear_at = -1;
  int run_at = -1;
  int err_at = -1;
  int elig = 0;
  int wait_start = 0;

  task automatic start_seq(input int s);
    k        = 0;
    run      = 1'b0;
    waiting  = 1'b0;
    run_at   = -1;
    clear_at = s + A + 1;
  endtask

  // Compare process: every cycle, mid-period
  always @(negedge clk) begin
    logic [2:0] exp_rst;
    bit go;
    if (hi_edges < 2) begin
      armed = 1'b1; k = 0; run = 1'b0; waiting = 1'b0;
      clear_at = -1; run_at = -1; err_at = -1; exp_err = 1'b0;
      check("m_rst_stage_rst", int'(stage_rst), 7);
      check("m_rst_sys_ready", int'(sys_ready), 0);
      check("m_rst_busy", int'(busy), 1);
      check("m_rst_soft_ack", int'(soft_ack), 0);
      check("m_rst_err", int'(ack_timeout_err), 0);
    end else begin
      if (armed) begin
        armed = 1'b0;
        start_seq(cyc);
      end
      if (cyc == clear_at) begin
        k++;
        clear_at   = -1;
        waiting    = 1'b1;
        elig       = cyc + G - 1;
        wait_start = cyc;
      end
      if (cyc == run_at) begin
        run    = 1'b1;
        run_at = -1;
      end
      if (cyc == err_at) begin
        exp_err = 1'b1;
        err_at  = -1;
      end
      exp_rst = 3'b111 << k;
      check("m_stage_rst", int'(stage_rst), int'(exp_rst));
      check("m_sys_ready", int'(sys_ready), int'(run));
      check("m_busy", int'(busy), int'(!run));
      check("m_soft_ack", int'(soft_ack), int'(run && soft_req));
      check("m_err", int'(ack_timeout_err), int'(exp_err));
      if (waiting && cyc >= elig) begin
        go = stage_ack[k-1];
`ifdef RSTSEQ_ACK_TIMEOUT_EN
        if (!go && (cyc - wait_start >= T - 1)) begin
          go     = 1'b1;
          err_at = cyc + 1;
        end
`endif
        if (go) begin
          waiting = 1'b0;
          if (k == N) run_at = cyc + 1;
          else clear_at = cyc + 2;
        end
      end
      if (run && soft_req) begin
        exp_err = 1'b0;
        err_at  = -1;
        start_seq(cyc + 1);
      end
    end
  end

  task automatic wait_rst(input logic [2:0] val, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (stage_rst === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sys_ready === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Pulse soft_req for one cycle from RUN; s is the first HOLD cycle afterwards
  task automatic soft_reset(output int s);
    @(posedge clk);
    #1 soft_req = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    check("soft_ack_pulse", int'(soft_ack), 1);
    @(posedge clk);
    #1 soft_req = 1'b0;
  endtask

  initial begin
    int s;
    int at;
    reset_n   = 1'b0;
    soft_req  = 1'b0;
    stage_ack = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stage_rst", int'(stage_rst), 7);
    check("reset_busy", int'(busy), 1);
    check("reset_sys_ready", int'(sys_ready), 0);

    // Basic sequence with all acks high
    @(posedge clk);
    #1 reset_n = 1'b1;
    s = cyc + 2;
    wait_rst(3'b110, 100, at); check("t1_stage0_at", at - s, 17);
    wait_rst(3'b100, 100, at); check("t1_stage1_at", at - s, 22);
    wait_rst(3'b000, 100, at); check("t1_stage2_at", at - s, 27);
    wait_ready(100, at);       check("t1_ready_at", at - s, 31);
    check("t1_busy_run", int'(busy), 0);

    // Soft reset from RUN, then soft_req during HOLD is ignored
    soft_reset(s);
    @(negedge clk);
    check("t3_stage_rst_after", int'(stage_rst), 7);
    check("t3_ready_after", int'(sys_ready), 0);
    check("t3_busy_after", int'(busy), 1);
    @(posedge clk);
    #1 soft_req = 1'b1;
    @(negedge clk);
    check("t3_hold_no_ack", int'(soft_ack), 0);
    @(posedge clk);
    #1 soft_req = 1'b0;
    wait_ready(100, at); check("t3_ready_at", at - s, 31);

    // Stage 1 ack arrives 20 cycles after its release
    stage_ack = 3'b101;
    soft_reset(s);
    wait_rst(3'b100, 100, at); check("t2_stage1_at", at - s, 22);
    repeat (20) @(posedge clk);
    #1 stage_ack = 3'b111;
    check("t2_stalled", int'(stage_rst), 4);
    wait_rst(3'b000, 100, at); check("t2_stage2_at", at - s, 44);
    wait_ready(100, at);       check("t2_ready_at", at - s, 48);

    // Asynchronous reset during stage 1 wait
    soft_reset(s);
    wait_rst(3'b100, 100, at); check("t4_stage1_at", at - s, 22);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t4_async_stage_rst", int'(stage_rst), 7);
    check("t4_async_busy", int'(busy), 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    s = cyc + 2;
    wait_rst(3'b110, 100, at); check("t4_stage0_at", at - s, 17);
    wait_ready(100, at);       check("t4_ready_at", at - s, 31);

`ifdef RSTSEQ_ACK_TIMEOUT_EN
    // Stage 2 ack stuck low: forced after 64 waiting cycles
    stage_ack = 3'b011;
    soft_reset(s);
    wait_ready(200, at); check("t5_ready_at", at - s, 91);
    check("t5_err_set", int'(ack_timeout_err), 1);
    @(posedge clk);
    #1 stage_ack = 3'b111;
    soft_reset(s);
    @(negedge clk);
    check("t5_err_cleared", int'(ack_timeout_err), 0);
    wait_ready(100, at); check("t5_ready_again", at - s, 31);
`else
    // Stage 0 ack stuck low: waits indefinitely
    stage_ack = 3'b110;
    soft_reset(s);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("t6_stage_rst", int'(stage_rst), 6);
    check("t6_busy", int'(busy), 1);
    check("t6_err", int'(ack_timeout_err), 0);
    @(posedge clk);
    #1 stage_ack = 3'b111;
    wait_ready(100, at); check("t6_ready_found", int'(at > 0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Reset controller sitting between the board reset pin and the processor subsystems (memory, register file, core).
- Holds every subsystem in reset for a fixed time, then releases them one at a time in index order.
- Each release waits a minimum gap and a ready acknowledge from that subsystem before the next one is released.
- Accepts a soft-reset request from the running system and re-runs the full sequence.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs; stage 0 is released first.
ASSERT_CYCLES, 16, cycles all stages are held in reset before the first release; range 1..2**CNT_W-1.
GAP_CYCLES, 4, minimum cycles after a release before the next stage is released; range 1..2**CNT_W-1.
CNT_W, 8, width of the internal cycle counters.
ACK_TIMEOUT, 64, WAIT_ACK cycles before a missing acknowledge is forced; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
soft_req  in  1  soft-reset request, level-sampled every cycle.
stage_ack  in  NUM_STAGES  per-stage "out of reset and ready"; bit i is examined only while waiting on stage i.
stage_rst  out  NUM_STAGES  per-stage reset, active-high, registered.
sys_ready  out  1  high only in RUN.
busy  out  1  high in every state except RUN.
soft_ack  out  1  one-cycle pulse when soft_req is accepted.
ack_timeout_err  out  1  sticky acknowledge-timeout flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset input path:
  - reset_n low asserts the internal reset immediately (asynchronous).
  - Deassertion passes through a 2-flop synchroniser; the internal reset drops on the 2nd rising edge after reset_n goes high.
- Values while the internal reset is active:
  - stage_rst all ones, sys_ready 0, busy 1, soft_ack 0, ack_timeout_err 0.
  - state HOLD, all counters 0, stage index 0.
- HOLD:
  - stage_rst is all ones.
  - The counter increments each cycle; HOLD lasts exactly ASSERT_CYCLES cycles, then moves to RELEASE with index 0.
- RELEASE:
  - Lasts exactly 1 cycle.
  - stage_rst[idx] is cleared on the edge that ends this state.
  - The gap counter is cleared; next state is WAIT_ACK.
- WAIT_ACK:
  - Lasts at least GAP_CYCLES cycles.
  - Exits on the first cycle where the gap counter is GAP_CYCLES-1 or higher and stage_ack[idx]=1.
  - If idx = NUM_STAGES-1, go to RUN; otherwise idx+1 and go to RELEASE.
  - The gap counter saturates and does not wrap.
- RUN:
  - sys_ready 1, busy 0.
  - If soft_req=1: soft_ack pulses 1 for that cycle; the next edge sets stage_rst to all ones, clears counters, index and ack_timeout_err, and enters HOLD.
- Release timing: stage_rst bits clear in ascending index order only. Previously released stages stay released until a full reassert.
- soft_req outside RUN is ignored and gets no soft_ack; the requester must retry after sys_ready.
  - If soft_req is held high continuously, the sequence restarts every time it reaches RUN; the requester drops soft_req after soft_ack.
- stage_ack changes outside the matching WAIT_ACK have no effect, including an ack dropping while in RUN.
- reset_n low at any point (mid-HOLD, mid-WAIT_ACK, RUN) returns all outputs to reset values immediately; the sequence restarts from HOLD.
- Cycle count with acks held high, measured from the first HOLD cycle:
  - stage_rst[i] clears after ASSERT_CYCLES + 1 + i*(GAP_CYCLES+1) cycles.
  - sys_ready rises after ASSERT_CYCLES + NUM_STAGES*(GAP_CYCLES+1) cycles.
  - Defaults: stage 0 at 17, stage 1 at 22, stage 2 at 27, sys_ready at 31.

Optional Feature:
- Macro: RSTSEQ_ACK_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in WAIT_ACK.
  - If stage_ack[idx] stays 0 for ACK_TIMEOUT cycles, ack_timeout_err is set (sticky) and the FSM proceeds as if the acknowledge had arrived.
  - The flag clears only on reset or on an accepted soft reset.
- Not defined: WAIT_ACK waits indefinitely for the acknowledge; ack_timeout_err is constant 0 and there is no timeout counter.

Test Plan:
- Defaults, stage_ack=3'b111, release reset_n -> stage_rst 111 for the first 17 HOLD/RELEASE cycles, then 110 @17, 100 @22, 000 @27; sys_ready=1 and busy=0 @31.
- stage_ack[1] held 0 until 20 cycles after stage 1 is released -> stage_rst stays 100 until the ack arrives; stage 2 releases GAP_CYCLES+1 cycles later at the earliest.
- In RUN, soft_req pulsed 1 cycle -> soft_ack=1 in that cycle; stage_rst=111, sys_ready=0, busy=1 next cycle; the full 31-cycle sequence repeats. soft_req during HOLD -> no soft_ack, no effect.
- reset_n pulsed low during WAIT_ACK of stage 1 -> stage_rst=111 asynchronously (before the next edge); the sequence restarts 2 edges after reset_n rises.
- With RSTSEQ_ACK_TIMEOUT_EN, stage_ack[2] stuck 0 -> ack_timeout_err=1 after 64 WAIT_ACK cycles; sys_ready=1 next cycle; the flag clears on an accepted soft_req.
- Without the macro, stage_ack[0] stuck 0 for 1000 cycles -> stage_rst=110, busy=1, ack_timeout_err=0 throughout.
